pc_gen: RTL and testbench

Parametrised program-counter generator for the single-cycle core. It is the successor of the plain PC register. It adds:
- a configurable reset vector
- sequential increment
- stall hold
- branch/jump redirect
- trap redirect, with misaligned-target detection
- halt/resume control
- a retired-instruction counter

It sits at the head of the fetch path. It drives instruction-memory address and supplies pc/pc_plus_inc to the datapath.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_retire_cnt.sv | 25 ++
 rtl/pc_gen.sv | 133 +++++++++++++
 tb/tb_pc_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default vectors for the program-counter generator
//
// Contents:
//   state_t  : BOOT / RUN / HALT control state (2-bit)
//   pc_sel_t : next-pc source select (SEL_TRAP, SEL_REDIR, SEL_HOLD, SEL_INC)
//   DEF_RESET_VECTOR / DEF_TRAP_VECTOR : default 32-bit vectors
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_TRAP  = 2'd0,
        SEL_REDIR = 2'd1,
        SEL_HOLD  = 2'd2,
        SEL_INC   = 2'd3
    } pc_sel_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_retire_cnt.sv
// rtl/pc_retire_cnt.sv - wrap-around enable counter for retired instructions
//
// Ports:
//   clk     in   rising-edge clock
//   reset_n in   asynchronous active-low clear
//   en      in   count this cycle
//   cnt     out  CNT_W-bit count, wraps modulo 2^CNT_W
module pc_retire_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator with redirect, trap, halt and retire count
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   stall                   hold pc this cycle
//   redirect_valid/_target  branch/jump redirect
//   trap_valid              exception/interrupt request
//   halt_req, resume        HALT entry / exit
//   pc, pc_plus_inc         current fetch address and pc + INC
//   pc_valid                pc is a real fetch (RUN)
//   misalign                one-cycle pulse after a misaligned redirect
//   epc                     pc captured on trap / misaligned redirect
//   retire_cnt              issued-instruction count
//   halted                  state is HALT
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
    parameter int              INC          = 4,
    parameter int              ALIGN_BITS   = 2,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic             halt_req,
    input  logic             resume,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus_inc,
    output logic             pc_valid,
    output logic             misalign,
    output logic [XLEN-1:0]  epc,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halted
);

    // Mask form keeps ALIGN_BITS = 0 legal (no zero-width slice).
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'(1) << ALIGN_BITS) - 64'(1));

    state_t  state;
    pc_sel_t sel;
    logic    target_misaligned;
    logic    take_misalign;
    logic    retire_en;

    assign pc_plus_inc       = pc + XLEN'(INC);
    assign target_misaligned = |(redirect_target & ALIGN_MASK);

    // Only a misaligned redirect that is not pre-empted by a real trap pulses misalign.
    assign take_misalign = (state == RUN) && !trap_valid && redirect_valid && target_misaligned;

    always_comb begin
        sel = SEL_INC;
        if (state != RUN) begin
            sel = SEL_HOLD;
        end else if (trap_valid || take_misalign) begin
            sel = SEL_TRAP;
        end else if (redirect_valid) begin
            sel = SEL_REDIR;
        end else if (stall) begin
            sel = SEL_HOLD;
        end
    end

    // Trap/redirect cycles still retire the instruction at pc; only stalls do not.
    assign retire_en = (state == RUN) && !stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BOOT;
            pc       <= RESET_VECTOR;
            pc_valid <= 1'b0;
            misalign <= 1'b0;
            epc      <= '0;
            halted   <= 1'b0;
        end else begin
            misalign <= take_misalign;

            case (sel)
                SEL_TRAP: begin
                    pc  <= TRAP_VECTOR;
                    epc <= pc;
                end
                SEL_REDIR: pc <= redirect_target;
                SEL_INC:   pc <= pc_plus_inc;
                default:   pc <= pc;
            endcase

            // pc_valid/halted are registered with state so they line up with pc.
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (halt_req) begin
                        state    <= HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end
                end
                HALT: begin
                    // A still-asserted halt_req wins over resume.
                    if (resume && !halt_req) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

    pc_retire_cnt #(
        .CNT_W (CNT_W)
    ) u_retire_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (retire_en),
        .cnt     (retire_cnt)
    );

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen
module tb_pc_gen;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus_inc;
    logic        pc_valid;
    logic        misalign;
    logic [31:0] epc;
    logic [31:0] retire_cnt;
    logic        halted;

    pc_gen dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .halt_req        (halt_req),
        .resume          (resume),
        .pc              (pc),
        .pc_plus_inc     (pc_plus_inc),
        .pc_valid        (pc_valid),
        .misalign        (misalign),
        .epc             (epc),
        .retire_cnt      (retire_cnt),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: architectural view of the fetch unit.
    logic        m_booting;
    logic        m_halted;
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_cnt;
    logic        m_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_booting = 1'b1;
        m_halted  = 1'b0;
        m_pc      = 32'h0;
        m_epc     = 32'h0;
        m_cnt     = 32'h0;
        m_mis     = 1'b0;
    endtask

    task automatic model_edge();
        m_mis = 1'b0;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_halted) begin
            if (resume && !halt_req) m_halted = 1'b0;
        end else begin
            if (!stall) m_cnt = m_cnt + 1;
            if (trap_valid) begin
                m_epc = m_pc;
                m_pc  = 32'h100;
            end else if (redirect_valid && (redirect_target % 4 != 0)) begin
                m_epc = m_pc;
                m_pc  = 32'h100;
                m_mis = 1'b1;
            end else if (redirect_valid) begin
                m_pc = redirect_target;
            end else if (!stall) begin
                m_pc = m_pc + 4;
            end
            if (halt_req) m_halted = 1'b1;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},          pc,                 m_pc);
        chk({tag, ".pc_plus_inc"}, pc_plus_inc,        m_pc + 32'd4);
        chk({tag, ".pc_valid"},    32'(pc_valid),      32'(!m_booting && !m_halted));
        chk({tag, ".misalign"},    32'(misalign),      32'(m_mis));
        chk({tag, ".epc"},         epc,                m_epc);
        chk({tag, ".retire_cnt"},  retire_cnt,         m_cnt);
        chk({tag, ".halted"},      32'(halted),        32'(m_halted));
    endtask

    task automatic step(input string tag, input logic st, input logic rv, input logic [31:0] tgt,
                        input logic tv, input logic hr, input logic rs);
        stall           = st;
        redirect_valid  = rv;
        redirect_target = tgt;
        trap_valid      = tv;
        halt_req        = hr;
        resume          = rs;
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        stall = 0; redirect_valid = 0; redirect_target = 0;
        trap_valid = 0; halt_req = 0; resume = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk_all("reset");
        reset_n = 1'b1;
        #1;
        chk_all("boot");

        // Sequential fetch from the reset vector.
        step("run0", 0, 0, 0, 0, 0, 0);
        chk("first_pc", pc, 32'h0);
        step("run1", 0, 0, 0, 0, 0, 0);
        step("run2", 0, 0, 0, 0, 0, 0);
        chk("cnt_after_two", retire_cnt, 32'd2);

        // Stall holds pc and count.
        step("stall0", 1, 0, 0, 0, 0, 0);
        step("stall1", 1, 0, 0, 0, 0, 0);
        chk("stall_pc", pc, 32'h8);
        step("unstall", 0, 0, 0, 0, 0, 0);

        // Redirect beats stall.
        step("redir_stall", 1, 1, 32'h40, 0, 0, 0);
        chk("redir_pc", pc, 32'h40);
        step("after_redir", 0, 0, 0, 0, 0, 0);

        // Misaligned redirect, then trap beating an aligned redirect.
        step("to10", 0, 1, 32'h10, 0, 0, 0);
        step("mis", 0, 1, 32'h42, 0, 0, 0);
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_epc", epc, 32'h10);
        step("mis_gone", 0, 0, 0, 0, 0, 0);
        step("trap", 0, 1, 32'h80, 1, 0, 0);
        chk("trap_epc", epc, 32'h104);

        // Halt, ignored requests, resume.
        step("to20", 0, 1, 32'h20, 0, 0, 0);
        step("halt", 0, 0, 0, 0, 1, 0);
        chk("halt_pc", pc, 32'h24);
        step("h_redir", 0, 1, 32'h80, 0, 0, 0);
        step("h_trap", 1, 0, 0, 1, 0, 0);
        step("h_both", 0, 0, 0, 0, 1, 1);
        step("resume", 0, 0, 0, 0, 0, 1);
        step("post_resume", 0, 0, 0, 0, 0, 1);
        chk("resume_pc", pc, 32'h28);

        // trap together with halt_req.
        step("trap_halt", 0, 0, 0, 1, 1, 0);
        step("trap_halt_hold", 0, 0, 0, 0, 0, 0);
        step("resume2", 0, 0, 0, 0, 0, 1);

        // Wrap-around.
        step("tohigh", 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        step("wrap", 0, 0, 0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            step("rand",
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 tgt,
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        // Make sure we are running, then reset between edges.
        step("pre_rst_resume", 0, 0, 0, 0, 0, 1);
        step("pre_rst", 0, 0, 0, 0, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        chk("async_rst_cnt", retire_cnt, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step("rst_boot_exit", 0, 1, 32'h40, 1, 0, 0);
        step("rst_run", 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
